handshake_elastic_fifo: RTL and testbench
=========================================

// Module: handshake_elastic_fifo
// PURPOSE
//  Elastic FIFO for the handshake (valid/ready) dataflow fabric. Sits directly downstream of
//  handshake constant/operator units and stores tokens they emit on outs/outs_valid.
//  Breaks the combinational valid/data path and the ready path between producer and consumer.
//  With NUM_SLOTS>=2 it sustains one token per cycle; it also absorbs short consumer stalls.
// PARAMETERS
//  DATA_WIDTH  32  token payload width in bits
//  NUM_SLOTS   2   token storage depth; >=1, need not be a power of two
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous, active-high reset
//  ins         in   DATA_WIDTH  input token payload (from upstream outs)
//  ins_valid   in   1           upstream token valid
//  ins_ready   out  1           FIFO can accept a token this cycle
//  outs        out  DATA_WIDTH  head-of-FIFO payload
//  outs_valid  out  1           head token valid
//  outs_ready  in   1           downstream accepts head token
// BEHAVIOUR
//  - Single clock clk; reset is synchronous and active-high on rst. All state updates on posedge clk.
//  - State: slot array mem[NUM_SLOTS], head/tail pointers, occupancy count (0..NUM_SLOTS).
//  - Reset: count=0, head=0, tail=0. While rst=1: ins_ready=0, outs_valid=0.
//    First cycle after rst falls: ins_ready=1, outs_valid=0. Slot contents are not reset.
//  - ins_ready = !rst && (count != NUM_SLOTS); depends only on registered state, never on outs_ready.
//  - outs_valid = !rst && (count != 0); outs = mem[head]. No combinational path from ins/ins_valid.
//  - push = ins_valid && ins_ready: mem[tail]<=ins, tail advances.
//  - pop = outs_valid && outs_ready: head advances.
//  - Pointer advance: p <= (p==NUM_SLOTS-1) ? 0 : p+1 (explicit wrap, non-pow2 safe).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Latency: a token pushed in cycle N is visible on outs with outs_valid=1 in cycle N+1 at
//    the earliest. There is no bypass: when empty, outs_valid stays 0 in the push cycle.
//  - Full (count==NUM_SLOTS): ins_ready=0 even if a pop occurs in the same cycle.
//    There is no ready bypass, so the full->not-full transition is visible one cycle later.
//  - Empty and simultaneous push: push accepted, no pop, count becomes 1.
//  - Partial occupancy with simultaneous push and pop: both occur and count is unchanged.
//  - Throughput: NUM_SLOTS=1 gives at most 1 token per 2 cycles; NUM_SLOTS>=2 gives 1 token/cycle.
//  - Ordering: strict FIFO. No token loss or duplication under any valid/ready pattern.
//  - outs holds mem[head] stable while outs_valid=1 && outs_ready=0 (handshake persistence).
//  - outs is don't-care when outs_valid=0.
//  - Mid-operation reset: all stored tokens are discarded. Behaviour afterwards is as after power-up reset.
//  - Protocol assumption checked by the bench: upstream holds ins/ins_valid stable until accepted.
//  - Pointer width PTR_W=$clog2(NUM_SLOTS) (min 1). Count width CNT_W=$clog2(NUM_SLOTS+1).
// STRUCTURE
//  - Shared package handshake_pkg: function clog2_min1(n) for pointer/count widths, and
//    localparam HS_DEFAULT_WIDTH=32 so constant producers and buffers agree on the default width.
//  - No sub-module: one storage always block, one pointer/count always block, continuous
//    assigns for ins_ready/outs_valid/outs. A small handshake_ptr_wrap increment helper may
//    live in handshake_pkg as a function; it is not a separate module.
// TESTING
//  1 Reset: hold rst=1 for 3 cycles with ins_valid=1 -> ins_ready=0 and outs_valid=0 throughout;
//    cycle after release -> ins_ready=1, outs_valid=0.
//  2 Streaming, NUM_SLOTS=2, outs_ready=1: push 0x1,0x2,...,0x10 back-to-back -> outs emits the
//    same sequence starting 1 cycle later, 16 tokens in 16 consecutive cycles, ins_ready=1 always.
//  3 Fill/stall: outs_ready=0, push 0xA,0xB -> ins_ready=0 from cycle 3; 0xC is held upstream.
//    Raise outs_ready -> outs=0xA then 0xB then 0xC, with no loss.
//  4 Full plus simultaneous pop: count=2 and outs_ready=1 in the same cycle as ins_valid=1 ->
//    pop accepted, push rejected; push accepted the next cycle; count ends at 2.
//  5 Wrap, NUM_SLOTS=3: random ins_valid/outs_ready (50%) for 1000 tokens with a scoreboard ->
//    exact in-order match; head/tail pass through 2->0 at least 100 times.
//  6 Mid-operation reset: 2 tokens stored, pulse rst for 1 cycle -> outs_valid=0 next cycle;
//    new token 0x55 pushed afterwards appears first on outs.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared handshake-fabric definitions: default token width and pointer/count sizing helpers.
package handshake_pkg;

  localparam int unsigned HS_DEFAULT_WIDTH = 32;

  // Width of a field able to index n distinct values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Explicit wrap so depths that are not a power of two index correctly.
  function automatic int unsigned handshake_ptr_wrap(input int unsigned p, input int unsigned n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/handshake_elastic_fifo.sv
// Elastic FIFO for the valid/ready fabric; registers both the valid/data path and the ready path.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DEFAULT_WIDTH,
  parameter int unsigned NUM_SLOTS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PTR_W = clog2_min1(NUM_SLOTS);
  localparam int unsigned CNT_W = clog2_min1(NUM_SLOTS + 1);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Ready looks only at stored occupancy, so a pop never frees a slot in the same cycle.
  assign ins_ready  = !rst && (count != CNT_W'(NUM_SLOTS));
  assign outs_valid = !rst && (count != '0);
  assign outs       = mem[head];

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= PTR_W'(handshake_ptr_wrap(32'(tail), NUM_SLOTS));
      end
      if (pop) begin
        head <= PTR_W'(handshake_ptr_wrap(32'(head), NUM_SLOTS));
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: 2-slot and 3-slot instances against a queue-based reference.
module tb_handshake_elastic_fifo;
  import handshake_pkg::*;

  localparam int unsigned W = HS_DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic [W-1:0] ins = '0;
  logic         ins_valid = 1'b0;
  logic         outs_ready = 1'b0;

  logic         rst2, rst3;
  logic         ready2, valid2, ready3, valid3;
  logic [W-1:0] outs2, outs3;
  logic         ins_ready_m, outs_valid_m;
  logic [W-1:0] outs_m;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  int unsigned  dut_pops = 0;
  int unsigned  wraps = 0;
  int unsigned  cyc = 0;
  logic [1:0]   prev_tail = '0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  // Only the selected instance runs; the other is parked in reset.
  assign rst2 = rst || sel;
  assign rst3 = rst || !sel;

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(2)) dut2 (
    .clk(clk), .rst(rst2), .ins(ins), .ins_valid(ins_valid), .ins_ready(ready2),
    .outs(outs2), .outs_valid(valid2), .outs_ready(outs_ready)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst3), .ins(ins), .ins_valid(ins_valid), .ins_ready(ready3),
    .outs(outs3), .outs_valid(valid3), .outs_ready(outs_ready)
  );

  assign ins_ready_m  = sel ? ready3 : ready2;
  assign outs_valid_m = sel ? valid3 : valid2;
  assign outs_m       = sel ? outs3  : outs2;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: occupancy is the queue depth; handshakes resolve at the next rising edge.
  always @(negedge clk) begin
    int unsigned  cap;
    logic         push_e, pop_e;
    logic [W-1:0] h;
    cap = sel ? 3 : 2;
    if (rst) begin
      check_eq("rst_ins_ready", ins_ready_m, 1'b0);
      check_eq("rst_outs_valid", outs_valid_m, 1'b0);
      q.delete();
    end else begin
      check_eq("ins_ready", ins_ready_m, q.size() != cap);
      check_eq("outs_valid", outs_valid_m, q.size() != 0);
      if (outs_valid_m && outs_ready) dut_pops++;
      push_e = ins_valid && (q.size() != cap);
      pop_e  = outs_ready && (q.size() != 0);
      if (pop_e) begin
        h = q.pop_front();
        check_eq("outs_data", outs_m, h);
      end
      if (push_e) q.push_back(ins);
    end
    if (prev_tail == 2'd2 && dut3.tail == 2'd0) wraps++;
    prev_tail = dut3.tail;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    logic acc;
    acc = 1'b0;
    ins = d;
    ins_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = ins_ready_m;
      tick();
      if (acc) begin
        ins_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", acc, 1'b1);
    ins_valid = 1'b0;
  endtask

  task automatic drain();
    ins_valid = 1'b0;
    outs_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!outs_valid_m) break;
      tick();
    end
    check_eq("drain_empty", outs_valid_m, 1'b0);
  endtask

  task automatic select(input logic s);
    rst = 1'b1;
    sel = s;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned  c0, p0, w0, sent;
    logic         acc;

    // Reset held with a token offered upstream
    ins = 32'h99;
    ins_valid = 1'b1;
    repeat (3) tick();
    check_eq("t1_ready_in_rst", ins_ready_m, 1'b0);
    check_eq("t1_valid_in_rst", outs_valid_m, 1'b0);
    rst = 1'b0;
    ins_valid = 1'b0;
    #1;
    check_eq("t1_ready_after", ins_ready_m, 1'b1);
    check_eq("t1_valid_after", outs_valid_m, 1'b0);
    tick();

    // Back-to-back streaming through two slots
    outs_ready = 1'b1;
    c0 = cyc;
    p0 = dut_pops;
    for (int i = 1; i <= 16; i++) send(W'(i));
    check_eq("t2_cycles", cyc - c0, 16);
    tick();
    check_eq("t2_pops", dut_pops - p0, 16);
    drain();

    // Fill with consumer stalled, hold a third token upstream
    outs_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    ins = 32'hC;
    ins_valid = 1'b1;
    repeat (3) tick();
    check_eq("t3_full", ins_ready_m, 1'b0);
    check_eq("t3_head", outs_m, 32'hA);
    outs_ready = 1'b1;
    send(32'hC);
    drain();

    // Full with simultaneous pop: push must wait one cycle
    outs_ready = 1'b0;
    send(32'h41);
    send(32'h42);
    outs_ready = 1'b1;
    ins = 32'h43;
    ins_valid = 1'b1;
    check_eq("t4_ready_full", ins_ready_m, 1'b0);
    tick();
    check_eq("t4_ready_next", ins_ready_m, 1'b1);
    outs_ready = 1'b0;
    tick();
    ins_valid = 1'b0;
    check_eq("t4_count", W'(dut2.count), 2);
    check_eq("t4_head", outs_m, 32'h42);
    drain();

    // Random traffic through the 3-slot instance
    select(1'b1);
    sent = 0;
    p0 = dut_pops;
    w0 = wraps;
    for (int c = 0; c < 20000; c++) begin
      if (sent == 1000 && dut_pops - p0 == 1000) break;
      if (!ins_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
        ins = $urandom;
        ins_valid = 1'b1;
      end
      outs_ready = ($urandom_range(1, 0) == 1);
      acc = ins_valid && ins_ready_m;
      tick();
      if (acc) begin
        ins_valid = 1'b0;
        sent++;
      end
    end
    check_eq("t5_tokens", dut_pops - p0, 1000);
    check_eq("t5_wraps", (wraps - w0) >= 100, 1'b1);
    drain();

    // Reset in the middle of operation discards stored tokens
    select(1'b0);
    tick();
    outs_ready = 1'b0;
    send(32'h61);
    send(32'h62);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_valid_after_rst", outs_valid_m, 1'b0);
    check_eq("t6_ready_after_rst", ins_ready_m, 1'b1);
    outs_ready = 1'b1;
    send(32'h55);
    check_eq("t6_first_valid", outs_valid_m, 1'b1);
    check_eq("t6_first_data", outs_m, 32'h55);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
